fir_spi_slave: RTL and testbench
================================

Name: fir_spi_slave

Overview:
SPI slave front-end that sits directly upstream of the FIR filter core. It receives 24-bit command frames from an external SPI master and converts them into the core's sample/coefficient load handshakes (sample_data, fir_coefficient, data_ready, load_coeff, paced by modwait). It captures the core's fir_out/err result when each computation finishes and returns it, with a status byte, over MISO.

Parameters:
TIMEOUT_CYCLES, 64, max clk cycles to wait for modwait to rise after a strobe before abandoning it
SYNC_STAGES, 2, synchronizer depth for sclk, ss_n and mosi

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sclk  in  1  SPI clock, mode 0, frequency <= clk/8
ss_n  in  1  SPI slave select, active low
mosi  in  1  SPI data in, MSB first
miso  out  1  SPI data out, MSB first
modwait  in  1  core busy flag
fir_out  in  16  core result
err  in  1  core error flag
sample_data  out  16  sample word to core
fir_coefficient  out  16  coefficient word to core
data_ready  out  1  sample strobe to core
load_coeff  out  1  coefficient strobe to core
overrun  out  1  sticky: frame dropped because core busy or strobe pending

Behaviour:
- Reset (async, active-high): all outputs 0; miso 0; shift/bit counters 0; result register 0; result_valid, err_latched, overrun, timeout flags 0; FSM IDLE.
- sclk/ss_n/mosi pass through SYNC_STAGES flops; rise/fall detected by comparison with one extra stage. Synchronized sclk rise -> shift mosi in. Synchronized sclk fall -> update miso.
- Frame: ss_n falls; 8-bit command, then 16-bit data, MSB first; 24 bits total.
- Bit count 24 reached and ss_n still low: frame complete; bits beyond 24 ignored; miso 0.
- ss_n rises before bit 24: frame discarded; no strobe, no flag change, counters cleared.
- Commands: 0x01 = LOAD_COEFF; 0x02 = SAMPLE; 0x03 = READ; any other value = NOP.
- miso during any frame: bits 0-7 output status byte {result_valid, err_latched, overrun, timeout, 4'b0}, snapshotted at the ss_n fall. Bits 8-23 output the 16-bit result register, also snapshotted at the ss_n fall. First bit is driven at the ss_n fall.
- Strobe FSM states: IDLE, STROBE, WAIT_DONE.
  - IDLE + complete SAMPLE/LOAD_COEFF frame with modwait=0:
    - drive data word on sample_data (SAMPLE) or fir_coefficient (LOAD_COEFF); register holds until the next accepted frame of the same type;
    - assert data_ready or load_coeff on the next clk; go to STROBE.
  - IDLE + complete frame with modwait=1, or any frame completing while not in IDLE: frame dropped; overrun set.
  - STROBE: strobe held high until modwait observed 1, then strobe deasserts the same cycle. Next state is WAIT_DONE for SAMPLE, IDLE for LOAD_COEFF.
  - STROBE: if TIMEOUT_CYCLES elapse with modwait=0, deassert strobe, set timeout, return to IDLE.
  - WAIT_DONE: on modwait 1->0, capture fir_out into the result register and err into err_latched, set result_valid, go to IDLE. There is no timeout in WAIT_DONE.
- READ frame complete: clear result_valid, overrun and timeout at that cycle. err_latched clears only on the next capture. A capture in the same cycle as the clear wins: result_valid=1.
- data_ready and load_coeff are never high simultaneously.
- Reset mid-frame or mid-strobe: immediate return to reset state; strobe drops asynchronously.

Decomposition:
- Package fir_spi_pkg:
  - command enum (CMD_NOP, CMD_LOAD_COEFF=8'h01, CMD_SAMPLE=8'h02, CMD_READ=8'h03);
  - strobe-state enum;
  - FRAME_BITS=24;
  - status-byte bit index constants.
- Sub-module spi_sync_edge: synchronizer plus rise/fall detect for sclk, with synchronized ss_n and mosi outputs. Instantiated once.

Test Plan:
- Reset mid-frame: assert rst after 10 bits of a SAMPLE frame, release, send SAMPLE 0x1234 -> sample_data=0x1234, data_ready high until modwait=1; no residue from the aborted frame.
- Coefficient load: send LOAD_COEFF 0x8000, modwait rises 3 cycles after load_coeff -> fir_coefficient=0x8000; load_coeff high exactly until modwait=1; FSM IDLE; result_valid stays 0.
- Sample + readback: SAMPLE 0x00FF; model drives modwait high 5 cycles, fir_out=0x0ABC, err=0, then modwait low. Next READ frame -> miso status byte 0x80, then 0x0ABC. A following READ -> status 0x00.
- Overrun: hold modwait=1, send SAMPLE 0x0001 -> no data_ready; overrun=1; status byte 0x20; cleared by READ.
- Timeout: SAMPLE with modwait held 0 -> data_ready high for exactly TIMEOUT_CYCLES cycles then 0; status byte 0x10.
- Short frame and NOP: ss_n raised after 12 bits, then a NOP (0x7F) frame -> no strobes; all flags unchanged; miso shows the current status/result.

Source files
------------

// File: rtl/fir_spi_pkg.sv
// fir_spi_pkg: shared command codes, strobe states, frame size and status-byte layout.
package fir_spi_pkg;
  typedef enum logic [7:0] {
    CMD_NOP        = 8'h00,
    CMD_LOAD_COEFF = 8'h01,
    CMD_SAMPLE     = 8'h02,
    CMD_READ       = 8'h03
  } cmd_t;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_STROBE    = 2'd1;
  localparam state_t ST_WAIT_DONE = 2'd2;
  localparam int FRAME_BITS = 24;
  localparam int STAT_VALID = 7;
  localparam int STAT_ERR   = 6;
  localparam int STAT_OVR   = 5;
  localparam int STAT_TMO   = 4;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: synchronizes sclk/ss_n/mosi into clk and flags sclk and ss_n edges.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_n_s,
  output logic ss_fall,
  output logic mosi_s
);
  logic [SYNC_STAGES:0] sclk_q, ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_q <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
      ss_q   <= {ss_q[SYNC_STAGES-1:0], ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign ss_n_s    = ss_q[SYNC_STAGES-1];
  assign ss_fall   = ~ss_q[SYNC_STAGES-1] & ss_q[SYNC_STAGES];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
endmodule

// File: rtl/fir_spi_slave.sv
// fir_spi_slave: SPI command front-end driving the FIR core load handshakes and returning results.
module fir_spi_slave
  import fir_spi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso,
  input  logic        modwait,
  input  logic [15:0] fir_out,
  input  logic        err,
  output logic [15:0] sample_data,
  output logic [15:0] fir_coefficient,
  output logic        data_ready,
  output logic        load_coeff,
  output logic        overrun
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic sclk_rise, sclk_fall, ss_n_s, ss_fall, mosi_s;
  logic [4:0] bit_cnt;
  logic [22:0] rx;
  logic [23:0] tx, word;
  logic [7:0] cmd, status;
  logic [15:0] result;
  logic result_valid, err_latched, timeout, is_coeff, modwait_q, frame_done, strobe_cmd;
  logic [TW-1:0] tmo_cnt;
  state_t state;
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .ss_n_s(ss_n_s),
    .ss_fall(ss_fall), .mosi_s(mosi_s)
  );
  always_comb begin
    status = '0;
    status[STAT_VALID] = result_valid;
    status[STAT_ERR]   = err_latched;
    status[STAT_OVR]   = overrun;
    status[STAT_TMO]   = timeout;
    word       = {rx, mosi_s};
    cmd        = word[23:16];
    frame_done = sclk_rise & ~ss_n_s & (bit_cnt == 5'(FRAME_BITS - 1));
    strobe_cmd = (cmd == CMD_SAMPLE) || (cmd == CMD_LOAD_COEFF);
  end
  // strobes drop combinationally the cycle modwait is seen, and with state on async reset
  assign data_ready = (state == ST_STROBE) & ~is_coeff & ~modwait;
  assign load_coeff = (state == ST_STROBE) & is_coeff & ~modwait;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bit_cnt <= '0;
      rx      <= '0;
      tx      <= '0;
      miso    <= 1'b0;
    end else if (ss_fall) begin
      bit_cnt <= '0;
      tx      <= {status, result};
      miso    <= status[STAT_VALID];
    end else if (ss_n_s) begin
      bit_cnt <= '0;
      miso    <= 1'b0;
    end else begin
      if (sclk_rise && bit_cnt < 5'(FRAME_BITS)) begin
        rx      <= {rx[21:0], mosi_s};
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (sclk_fall) begin
        tx   <= {tx[22:0], 1'b0};
        miso <= tx[22];
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= ST_IDLE;
      is_coeff        <= 1'b0;
      tmo_cnt         <= '0;
      sample_data     <= '0;
      fir_coefficient <= '0;
      result          <= '0;
      result_valid    <= 1'b0;
      err_latched     <= 1'b0;
      overrun         <= 1'b0;
      timeout         <= 1'b0;
      modwait_q       <= 1'b0;
    end else begin
      modwait_q <= modwait;
      if (frame_done && cmd == CMD_READ) begin
        result_valid <= 1'b0;
        overrun      <= 1'b0;
        timeout      <= 1'b0;
      end
      if (frame_done && strobe_cmd) begin
        if (state == ST_IDLE && !modwait) begin
          state    <= ST_STROBE;
          is_coeff <= cmd == CMD_LOAD_COEFF;
          tmo_cnt  <= '0;
          if (cmd == CMD_LOAD_COEFF) fir_coefficient <= word[15:0];
          else sample_data <= word[15:0];
        end else overrun <= 1'b1;
      end
      if (state == ST_STROBE) begin
        if (modwait) state <= is_coeff ? ST_IDLE : ST_WAIT_DONE;
        else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state   <= ST_IDLE;
          timeout <= 1'b1;
        end else tmo_cnt <= tmo_cnt + 1'b1;
      end
      // capture is ordered last so it overrides a same-cycle READ clear
      if (state == ST_WAIT_DONE && modwait_q && !modwait) begin
        result       <= fir_out;
        err_latched  <= err;
        result_valid <= 1'b1;
        state        <= ST_IDLE;
      end
    end
endmodule

// File: tb/tb_fir_spi_slave.sv
// tb_fir_spi_slave: directed plus randomized frames checked against a flag/register model of the slave.
module tb_fir_spi_slave;
  localparam int T    = 64;
  localparam int HALF = 5;
  logic clk = 0, rst = 1, sclk = 0, ss_n = 1, mosi = 0, modwait = 0, err = 0;
  logic [15:0] fir_out = '0;
  logic miso, data_ready, load_coeff, overrun;
  logic [15:0] sample_data, fir_coefficient;
  int checks = 0, errors = 0;
  int dr_run = 0, dr_len = 0, dr_pulses = 0, lc_run = 0, lc_pulses = 0, both = 0;
  bit m_valid = 0, m_err = 0, m_ovr = 0, m_tmo = 0;
  logic [15:0] m_result = '0, m_sample = '0, m_coeff = '0;
  logic [23:0] r;
  logic [15:0] d, fo;
  logic e;
  int p0, l0;

  fir_spi_slave #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .modwait(modwait), .fir_out(fir_out), .err(err), .sample_data(sample_data),
    .fir_coefficient(fir_coefficient), .data_ready(data_ready), .load_coeff(load_coeff),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_ready) dr_run++;
    else begin
      if (dr_run != 0) begin dr_len = dr_run; dr_pulses++; end
      dr_run = 0;
    end
    if (load_coeff) lc_run++;
    else begin
      if (lc_run != 0) lc_pulses++;
      lc_run = 0;
    end
    if (data_ready && load_coeff) both++;
  end

  function automatic logic [7:0] m_status();
    return {m_valid, m_err, m_ovr, m_tmo, 4'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [23:0] w, input int nbits, input bit keep, output logic [23:0] rd);
    rd = '0;
    ss_n = 0;
    cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[23-i];
      cyc(HALF);
      sclk = 1;
      rd[23-i] = miso;
      cyc(HALF);
      sclk = 0;
    end
    if (!keep) begin
      cyc(HALF);
      ss_n = 1;
      mosi = 0;
      cyc(HALF);
    end
  endtask

  task automatic do_read(input string tag, output logic [23:0] rd);
    xfer(24'h030000, 24, 0, rd);
    chk(tag, rd, {m_status(), m_result});
    m_valid = 0; m_ovr = 0; m_tmo = 0;
    @(negedge clk);
    chk({tag, "_ovr"}, overrun, 1'b0);
  endtask

  task automatic do_sample(input string tag, input logic [15:0] dv, input int busy, input logic [15:0] fv, input logic ev);
    xfer({8'h02, dv}, 24, 0, r);
    @(negedge clk);
    chk({tag, "_dr"}, data_ready, 1'b1);
    chk({tag, "_data"}, sample_data, dv);
    cyc(1);
    modwait = 1;
    @(negedge clk);
    chk({tag, "_drop"}, data_ready, 1'b0);
    cyc(busy);
    fir_out = fv; err = ev;
    modwait = 0;
    cyc(3);
    m_result = fv; m_err = ev; m_valid = 1; m_sample = dv;
  endtask

  task automatic do_coeff(input string tag, input logic [15:0] dv);
    xfer({8'h01, dv}, 24, 0, r);
    @(negedge clk);
    chk({tag, "_lc"}, load_coeff, 1'b1);
    chk({tag, "_data"}, fir_coefficient, dv);
    cyc(3);
    modwait = 1;
    @(negedge clk);
    chk({tag, "_drop"}, load_coeff, 1'b0);
    cyc(2);
    modwait = 0;
    cyc(3);
    m_coeff = dv;
  endtask

  initial begin
    cyc(3);
    chk("rst_miso", miso, 1'b0);
    chk("rst_outs", {data_ready, load_coeff, overrun, sample_data, fir_coefficient}, '0);
    rst = 0;
    cyc(3);
    // reset in the middle of a SAMPLE frame
    xfer(24'h02ABCD, 10, 1, r);
    rst = 1;
    cyc(1);
    chk("midrst_outs", {data_ready, load_coeff, overrun, miso, sample_data}, '0);
    ss_n = 1; sclk = 0; mosi = 0;
    cyc(2);
    rst = 0;
    cyc(2);
    p0 = dr_pulses;
    do_sample("midrst_smp", 16'h1234, 4, 16'h5A5A, 1'b0);
    chk("midrst_pulses", dr_pulses - p0, 1);
    do_read("midrst_read", r);
    // coefficient load must not touch result_valid
    do_coeff("coeff", 16'h8000);
    do_read("coeff_read", r);
    chk("coeff_status", r[23:16], 8'h00);
    // sample then readback
    do_sample("rb_smp", 16'h00FF, 5, 16'h0ABC, 1'b0);
    do_read("rb_read1", r);
    chk("rb_status1", r, 24'h800ABC);
    do_read("rb_read2", r);
    chk("rb_status2", r[23:16], 8'h00);
    // overrun while core busy
    modwait = 1;
    cyc(2);
    p0 = dr_pulses;
    xfer(24'h020001, 24, 0, r);
    @(negedge clk);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_nodr", dr_pulses + dr_run - p0, 0);
    chk("ovr_hold", sample_data, m_sample);
    m_ovr = 1;
    modwait = 0;
    cyc(3);
    do_read("ovr_read", r);
    chk("ovr_status", r[23:16], 8'h20);
    // strobe timeout
    p0 = dr_pulses;
    xfer(24'h024321, 24, 0, r);
    cyc(T + 20);
    chk("tmo_len", dr_len, T);
    chk("tmo_pulses", dr_pulses - p0, 1);
    m_tmo = 1; m_sample = 16'h4321;
    do_read("tmo_read", r);
    chk("tmo_status", r[23:16], 8'h10);
    // short frame and NOP
    do_sample("pre_nop", 16'h7777, 2, 16'hBEEF, 1'b1);
    p0 = dr_pulses; l0 = lc_pulses;
    xfer(24'h025555, 12, 0, r);
    xfer(24'h7F1234, 24, 0, r);
    chk("nop_miso", r, {m_status(), m_result});
    chk("nop_strobes", (dr_pulses - p0) + (lc_pulses - l0), 0);
    chk("nop_regs", {sample_data, overrun}, {m_sample, 1'b0});
    // randomized operations
    for (int k = 0; k < 10; k++) begin
      d  = 16'($urandom);
      fo = 16'($urandom);
      e  = 1'($urandom);
      case ($urandom_range(0, 3))
        0: do_sample("rnd_smp", d, $urandom_range(1, 6), fo, e);
        1: do_coeff("rnd_coeff", d);
        2: do_read("rnd_read", r);
        default: begin
          p0 = dr_pulses; l0 = lc_pulses;
          xfer({8'($urandom_range(4, 255)), d}, 24, 0, r);
          chk("rnd_nop", r, {m_status(), m_result});
          chk("rnd_nop_strobes", (dr_pulses - p0) + (lc_pulses - l0), 0);
        end
      endcase
    end
    do_read("final_read", r);
    chk("final_coeff", fir_coefficient, m_coeff);
    chk("never_both", both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
